// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter core.
// Contents:
//   WIDTH / AMT_W / STAGES   datapath width, shift-amount width, shift stage count
//   op_e                     operation codes (11 is reserved and shifts logically)
//   stage_t                  per-stage payload carried down the pipe
//   fill_bit()               vacated-MSB fill value for a newly accepted word
package barrel_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned AMT_W  = 5;
  localparam int unsigned STAGES = 5;

  typedef enum logic [1:0] {
    OP_LSL_LSR = 2'b00,
    OP_ASR     = 2'b01,
    OP_ROR     = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [AMT_W-1:0] amt;
    op_e              op;
    logic             dir;
    logic             fill;
    logic             valid;
  } stage_t;

  // Only a right-going arithmetic shift replicates the sign bit; a left
  // arithmetic shift arrives bit-reversed and must fill with zeros.
  function automatic logic fill_bit(input logic [WIDTH-1:0] data,
                                    input op_e              op,
                                    input logic             dir);
    return ((op == OP_ASR) && !dir) ? data[WIDTH-1] : 1'b0;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One conditional right-shift step of the barrel shifter plus its payload
// register. Shifts by SHAMT when the matching amount bit of the incoming
// payload is set, otherwise passes the data through.
// Build option: ROTATE_EN enables rotate-right for OP_ROR.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           load enable (global pipeline advance)
//   prev         payload from the preceding stage
//   cur          registered payload of this stage
module shift_stage
  import barrel_pkg::*;
#(
  parameter int unsigned SHAMT = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  stage_t prev,
  output stage_t cur
);

  localparam int unsigned AMT_BIT = $clog2(SHAMT);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = prev.data;
    if (prev.amt[AMT_BIT]) begin
      shifted = {{SHAMT{prev.fill}}, prev.data[WIDTH-1:SHAMT]};
`ifdef ROTATE_EN
      if (prev.op == OP_ROR) begin
        shifted = {prev.data[SHAMT-1:0], prev.data[WIDTH-1:SHAMT]};
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= '0;
    end else if (en) begin
      cur      <= prev;
      cur.data <= shifted;
    end
  end

endmodule

// File: rtl/shift_pipe_core.sv
// Five-stage pipelined 32-bit right-shift/rotate core. Left shifts arrive
// pre-reversed with in_dir=1; this core only shifts right and forwards the
// direction tag. The whole pipe advances together when the output is free
// or empty; bubbles are kept, not collapsed.
// Build option: ROTATE_EN (op 10 rotates right; otherwise shifts logically).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           input handshake (in_ready = advance)
//   in_data, in_amt, in_op, in_dir   operand, amount 0..31, op code, direction
//   out_valid/out_ready         output handshake
//   out_data, out_dir           result and its direction tag
module shift_pipe_core
  import barrel_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_dir
);

  logic   adv;
  stage_t in_stage;
  stage_t chain [0:STAGES];

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Input capture register: fill is resolved here so the shift stages see a
  // registered operand and there is no path from in_* to out_*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_stage <= '0;
    end else if (adv) begin
      in_stage.data  <= in_data;
      in_stage.amt   <= in_amt;
      in_stage.op    <= op_e'(in_op);
      in_stage.dir   <= in_dir;
      in_stage.fill  <= fill_bit(in_data, op_e'(in_op), in_dir);
      in_stage.valid <= in_valid;
    end
  end

  assign chain[0] = in_stage;

  // Stage k shifts by 16 >> k, consuming amount bit 4-k.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    shift_stage #(
      .SHAMT ((WIDTH / 2) >> k)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .prev  (chain[k]),
      .cur   (chain[k+1])
    );
  end

  assign out_valid = chain[STAGES].valid;
  assign out_data  = chain[STAGES].data;
  assign out_dir   = chain[STAGES].dir;

  logic unused_tail;
  assign unused_tail = ^{chain[STAGES].amt, chain[STAGES].op, chain[STAGES].fill};

endmodule
